mem_arbiter: RTL and testbench

- Shares the single RAM port between the instruction-cache controller (read-only) and the data-cache controller (read, write, write-back-then-refill).
- Sits between both cache controllers and the memory controller.
- Grants one requester at a time and holds the grant until memory signals completion.
- Sequences the data-cache write-back→allocate pair as one atomic grant.

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one RAM port between the I-cache and D-cache controllers.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration on ties.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_MemRead,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_ready,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [ADDR_W-1:0] dc_wb_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  input  logic              dc_MemRead,
  input  logic              dc_MemWrite,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_IC_RD = 3'd1;
  localparam logic [2:0] S_DC_WR = 3'd2;
  localparam logic [2:0] S_DC_RD = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]        state;
  logic              wb;
  logic [ADDR_W-1:0] fill_addr;
  logic              dc_req;
  logic              pick_dc;
  logic              done_ic;
  logic              done_dc;

  assign dc_req  = dc_MemRead | dc_MemWrite;
  assign done_ic = (state == S_IC_RD) && mem_ready;
  // DC_RD with the strobe low is the gap after a write-back
  assign done_dc = mem_ready &&
                   (((state == S_DC_WR) && !wb) ||
                    ((state == S_DC_RD) && mem_MemRead));

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_dc;

  assign pick_dc = dc_req && (!ic_MemRead || !last_dc);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      last_dc <= 1'b0;
    end else if (done_ic) begin
      last_dc <= 1'b0;
    end else if (done_dc) begin
      last_dc <= 1'b1;
    end
  end
`else
  assign pick_dc = dc_req;
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state        <= S_IDLE;
      wb           <= 1'b0;
      fill_addr    <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_MemRead  <= 1'b0;
      mem_MemWrite <= 1'b0;
      ic_rdata     <= '0;
      dc_rdata     <= '0;
      ic_ready     <= 1'b0;
      dc_ready     <= 1'b0;
    end else begin
      ic_ready <= done_ic;
      dc_ready <= done_dc;
      case (state)
        S_IDLE: begin
          if (pick_dc) begin
            wb           <= dc_MemWrite & dc_MemRead;
            fill_addr    <= dc_addr;
            mem_addr     <= (dc_MemWrite & dc_MemRead) ?
                            dc_wb_addr : dc_addr;
            mem_wdata    <= dc_wdata;
            mem_MemWrite <= dc_MemWrite;
            mem_MemRead  <= ~dc_MemWrite;
            state        <= dc_MemWrite ? S_DC_WR : S_DC_RD;
          end else if (ic_MemRead) begin
            mem_addr    <= ic_addr;
            mem_MemRead <= 1'b1;
            state       <= S_IC_RD;
          end
        end
        S_IC_RD: begin
          if (done_ic) begin
            ic_rdata    <= mem_rdata;
            mem_MemRead <= 1'b0;
            state       <= S_RESP;
          end
        end
        S_DC_WR: begin
          if (mem_ready) begin
            mem_MemWrite <= 1'b0;
            if (wb) begin
              mem_addr <= fill_addr;
              state    <= S_DC_RD;
            end else begin
              state <= S_RESP;
            end
          end
        end
        S_DC_RD: begin
          if (!mem_MemRead) begin
            mem_MemRead <= 1'b1;
          end else if (mem_ready) begin
            dc_rdata    <= mem_rdata;
            mem_MemRead <= 1'b0;
            state       <= S_RESP;
          end
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cases plus random requests
// checked against a transaction-level model and memory responder.
module tb_mem_arbiter;

  typedef struct {
    logic [31:0] a;
    bit          we;
    logic [31:0] d;
    int          gap;
  } op_t;

  logic        iCLK;
  logic        iRST;
  logic [31:0] ic_addr;
  logic        ic_MemRead;
  logic [31:0] ic_rdata;
  logic        ic_ready;
  logic [31:0] dc_addr;
  logic [31:0] dc_wb_addr;
  logic [31:0] dc_wdata;
  logic        dc_MemRead;
  logic        dc_MemWrite;
  logic [31:0] dc_rdata;
  logic        dc_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_MemRead;
  logic        mem_MemWrite;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int          total = 0;
  int          bad = 0;
  int          ic_pulses = 0;
  int          dc_pulses = 0;
  int          lat = 0;
  bit          spur = 0;
  time         t_raise = 0;
  bit          m_last_dc = 0;
  logic [31:0] exp_ic = '0;
  logic [31:0] exp_dc = '0;
  logic [31:0] mem [logic [31:0]];
  op_t         txq [$];
  op_t         cur;
  bit          busy = 0;
  int          cnt = 0;
  int          idle = 0;

  mem_arbiter dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .ic_addr     (ic_addr),
    .ic_MemRead  (ic_MemRead),
    .ic_rdata    (ic_rdata),
    .ic_ready    (ic_ready),
    .dc_addr     (dc_addr),
    .dc_wb_addr  (dc_wb_addr),
    .dc_wdata    (dc_wdata),
    .dc_MemRead  (dc_MemRead),
    .dc_MemWrite (dc_MemWrite),
    .dc_rdata    (dc_rdata),
    .dc_ready    (dc_ready),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_MemRead (mem_MemRead),
    .mem_MemWrite(mem_MemWrite),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_5A5A);
  endfunction

  // memory responder: logs each strobe, answers after lat cycles
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge iCLK);
      #1;
      if (iRST) begin
        busy = 0;
        mem_ready = 1'b0;
        idle = 0;
        continue;
      end
      if (mem_ready) begin
        mem_ready = 1'b0;
        busy = 0;
      end
      if (spur) begin
        spur = 0;
        mem_rdata = 32'h0BAD_0BAD;
        mem_ready = 1'b1;
        continue;
      end
      if (!(mem_MemRead | mem_MemWrite)) begin
        idle++;
      end else if (!busy) begin
        busy = 1;
        cnt = lat;
        cur.a = mem_addr;
        cur.we = mem_MemWrite;
        cur.d = mem_wdata;
        cur.gap = idle;
        txq.push_back(cur);
        idle = 0;
        if (cur.we) mem[cur.a] = cur.d;
      end else begin
        chk("hold_addr", 64'({mem_MemRead, mem_MemWrite, mem_addr}),
            64'({!cur.we, cur.we, cur.a}));
        if (cur.we) chk("hold_wdata", 64'(mem_wdata), 64'(cur.d));
      end
      if (busy) begin
        if (cnt == 0) begin
          mem_rdata = cur.we ? $urandom : rd(cur.a);
          mem_ready = 1'b1;
          t_raise = $time;
        end else begin
          cnt--;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge iCLK);
      if (!iRST) begin
        chk("one_strobe", 64'(mem_MemRead & mem_MemWrite), 64'(0));
        ic_pulses += int'(ic_ready);
        dc_pulses += int'(dc_ready);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic do_reset();
    ic_MemRead = 1'b0;
    dc_MemRead = 1'b0;
    dc_MemWrite = 1'b0;
    iRST = 1'b1;
    cyc(2);
    iRST = 1'b0;
    m_last_dc = 0;
    exp_ic = '0;
    exp_dc = '0;
  endtask

  task automatic wait_done(input bit want_ic, input bit want_dc);
    bit got_ic = 0;
    bit got_dc = 0;
    for (int i = 0; i < 200; i++) begin
      if ((got_ic || !want_ic) && (got_dc || !want_dc)) break;
      cyc(1);
      if (ic_ready && !got_ic) begin
        got_ic = 1;
        ic_MemRead = 1'b0;
        chk("ic_latency", 64'($time - t_raise), 64'(10));
      end
      if (dc_ready && !got_dc) begin
        got_dc = 1;
        dc_MemRead = 1'b0;
        dc_MemWrite = 1'b0;
        chk("dc_latency", 64'($time - t_raise), 64'(10));
      end
    end
    chk("ic_done", 64'(got_ic), 64'(want_ic));
    chk("dc_done", 64'(got_dc), 64'(want_dc));
    cyc(3);
  endtask

  // dk: 0 none, 1 read, 2 write, 3 write-back + refill
  task automatic scen(input bit ic_en, input logic [31:0] ia,
                      input int dk, input logic [31:0] da,
                      input logic [31:0] wa, input logic [31:0] wd,
                      input int ic_dly);
    op_t eq [$];
    op_t o;
    bit dc_en;
    bit dc_first;
    int p_ic;
    int p_dc;
    logic [31:0] e_ic;
    logic [31:0] e_dc;
    dc_en = (dk != 0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    dc_first = dc_en && (ic_dly > 0 || !ic_en || !m_last_dc);
`else
    dc_first = dc_en;
`endif
    e_ic = ic_en ? rd(ia) : exp_ic;
    e_dc = (dk == 1 || dk == 3) ? rd(da) : exp_dc;
    if (ic_en && !dc_first) begin
      o.a = ia; o.we = 0; o.d = '0; o.gap = -1;
      eq.push_back(o);
    end
    if (dk >= 2) begin
      o.a = (dk == 3) ? wa : da; o.we = 1; o.d = wd;
      o.gap = (eq.size() != 0) ? 2 : -1;
      eq.push_back(o);
    end
    if (dk == 1 || dk == 3) begin
      o.a = da; o.we = 0; o.d = '0;
      o.gap = (dk == 3) ? 1 : ((eq.size() != 0) ? 2 : -1);
      eq.push_back(o);
    end
    if (ic_en && dc_first) begin
      o.a = ia; o.we = 0; o.d = '0; o.gap = 2;
      eq.push_back(o);
    end
    if (ic_en && dc_en) m_last_dc = !dc_first;
    else m_last_dc = dc_en;

    txq.delete();
    p_ic = ic_pulses;
    p_dc = dc_pulses;
    dc_addr = da;
    dc_wb_addr = wa;
    dc_wdata = wd;
    dc_MemRead = (dk == 1 || dk == 3);
    dc_MemWrite = (dk >= 2);
    ic_addr = ia;
    if (ic_en && ic_dly == 0) ic_MemRead = 1'b1;
    cyc(1);
    chk("grant_strobe", 64'({mem_MemRead | mem_MemWrite, mem_addr}),
        64'({1'b1, eq[0].a}));
    if (ic_en && ic_dly > 0) begin
      cyc(ic_dly - 1);
      ic_MemRead = 1'b1;
    end
    wait_done(ic_en, dc_en);
    chk("op_count", 64'(txq.size()), 64'(eq.size()));
    for (int k = 0; k < eq.size() && k < txq.size(); k++) begin
      chk("op_addr", 64'(txq[k].a), 64'(eq[k].a));
      chk("op_write", 64'(txq[k].we), 64'(eq[k].we));
      if (eq[k].we) chk("op_wdata", 64'(txq[k].d), 64'(eq[k].d));
      if (eq[k].gap >= 0) chk("op_gap", 64'(txq[k].gap), 64'(eq[k].gap));
    end
    chk("ic_pulses", 64'(ic_pulses - p_ic), 64'(ic_en));
    chk("dc_pulses", 64'(dc_pulses - p_dc), 64'(dc_en));
    chk("ic_rdata", 64'(ic_rdata), 64'(e_ic));
    chk("dc_rdata", 64'(dc_rdata), 64'(e_dc));
    exp_ic = e_ic;
    exp_dc = e_dc;
  endtask

  initial begin
    int p_ic;
    int p_dc;
    iRST = 1'b1;
    ic_addr = '0;
    ic_MemRead = 1'b0;
    dc_addr = '0;
    dc_wb_addr = '0;
    dc_wdata = '0;
    dc_MemRead = 1'b0;
    dc_MemWrite = 1'b0;
    cyc(2);
    chk("rst_strobes", 64'({mem_MemRead, mem_MemWrite}), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_ready", 64'({ic_ready, dc_ready}), 64'(0));
    chk("rst_rdata", 64'({ic_rdata, dc_rdata}), 64'(0));
    iRST = 1'b0;
    cyc(2);

    mem[32'h100] = 32'hDEAD_BEEF;
    mem[32'h80] = 32'hCAFE_F00D;
    lat = 2;
    scen(1, 32'h100, 0, '0, '0, '0, 0);
    lat = 1;
    scen(0, '0, 3, 32'h80, 32'h40, 32'h1234_5678, 0);

    do_reset();
    cyc(1);
    lat = 0;
    scen(1, 32'h200, 1, 32'h300, '0, '0, 0);
    scen(1, 32'h200, 1, 32'h300, '0, '0, 0);

    lat = 4;
    scen(1, 32'h204, 1, 32'h304, '0, '0, 2);

    p_ic = ic_pulses;
    p_dc = dc_pulses;
    spur = 1;
    cyc(4);
    chk("spur_ic_pulse", 64'(ic_pulses - p_ic), 64'(0));
    chk("spur_dc_pulse", 64'(dc_pulses - p_dc), 64'(0));
    chk("spur_ic_rdata", 64'(ic_rdata), 64'(exp_ic));
    chk("spur_dc_rdata", 64'(dc_rdata), 64'(exp_dc));
    chk("spur_strobes", 64'({mem_MemRead, mem_MemWrite}), 64'(0));

    lat = 6;
    p_dc = dc_pulses;
    dc_addr = 32'h300;
    dc_MemRead = 1'b1;
    cyc(2);
    chk("pre_rst_strobe", 64'(mem_MemRead), 64'(1));
    #2 iRST = 1'b1;
    #1 chk("rst_async_strobe", 64'(mem_MemRead), 64'(0));
    dc_MemRead = 1'b0;
    cyc(2);
    iRST = 1'b0;
    m_last_dc = 0;
    exp_ic = '0;
    exp_dc = '0;
    cyc(4);
    chk("rst_no_dc_ready", 64'(dc_pulses - p_dc), 64'(0));
    chk("rst_idle_strobes", 64'({mem_MemRead, mem_MemWrite}), 64'(0));
    chk("rst_dc_rdata", 64'(dc_rdata), 64'(0));
    lat = 1;
    scen(1, 32'h100, 0, '0, '0, '0, 0);

    for (int n = 0; n < 40; n++) begin
      bit ie;
      int dk;
      ie = 1'($urandom_range(0, 1));
      dk = int'($urandom_range(0, 3));
      if (dk == 0) ie = 1;
      lat = int'($urandom_range(0, 3));
      scen(ie, $urandom & 32'h0FFF_FFFC, dk,
           ($urandom & 32'h0FFF_FFFC) | 32'h1000_0000,
           ($urandom & 32'h0FFF_FFFC) | 32'h2000_0000,
           $urandom, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
